duty_ramp_controller: RTL and testbench



---
 rtl/duty_ramp_controller_pkg.sv | 15 +
 rtl/duty_ramp_controller_ramp_tick_counter.sv | 38 +++
 rtl/duty_ramp_controller.sv | 125 ++++++++++++
 tb/tb_duty_ramp_controller.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/duty_ramp_controller_pkg.sv
// Shared types and default sizing for the duty ramp controller, the duty
// selector and the display.
package duty_ramp_controller_pkg;

    localparam int DUTY_W   = 6;
    localparam int DUTY_MAX = 50;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_OFF       = 2'd3
    } ramp_state_e;

endpackage

// File: rtl/duty_ramp_controller_ramp_tick_counter.sv
// Mod-RAMP_TICKS counter of PWM period ticks; strobes step on the wrapping tick.
module ramp_tick_counter #(
    parameter int RAMP_TICKS = 4
) (
    input  logic CLK,
    input  logic Reset,
    input  logic clr,
    input  logic tick,
    output logic step
);

    localparam int CW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(RAMP_TICKS - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (tick) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign step = tick && !clr && (count_q == LAST);

endmodule

// File: rtl/duty_ramp_controller.sv
// Ramps the applied PWM duty toward a button-controlled target, changing it only on period ticks.
// Optional DUTY_RAMP_SOFT_STOP_EN: disabling ramps duty down to 0 instead of dropping it.
module duty_ramp_controller
    import duty_ramp_controller_pkg::*;
#(
    parameter int W           = DUTY_W,
    parameter int MAX_DUTY    = DUTY_MAX,
    parameter int STEP        = 5,
    parameter int RAMP_TICKS  = 4,
    parameter int INIT_TARGET = 0
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         tick,
    input  logic         up,
    input  logic         down,
    input  logic         en,
    output logic [W-1:0] duty,
    output logic [W-1:0] target,
    output logic         busy,
    output logic         at_max,
    output logic         at_min
);

    localparam logic [W-1:0] MAX_W  = W'(MAX_DUTY);
    localparam logic [W:0]   MAX_W1 = (W+1)'(MAX_DUTY);
    localparam logic [W-1:0] STEP_W = W'(STEP);
    localparam logic [W:0]   STEP_W1 = (W+1)'(STEP);
    localparam logic [W-1:0] INIT_W = W'(INIT_TARGET);

    ramp_state_e  state_q, state_d;
    logic [W-1:0] duty_q, duty_d;
    logic [W-1:0] target_q, target_d;
    logic [W:0]   target_sum;
    logic [W-1:0] goal;
    logic         go_off;
    logic         cnt_clr;
    logic         step;

    ramp_tick_counter #(.RAMP_TICKS(RAMP_TICKS)) u_tick_cnt (
        .CLK   (CLK),
        .Reset (Reset),
        .clr   (cnt_clr),
        .tick  (tick),
        .step  (step)
    );

    // Target saturates at both ends; the lower bound is compared before subtracting.
    assign target_sum = {1'b0, target_q} + STEP_W1;

    always_comb begin
        target_d = target_q;
        if (up && !down) begin
            target_d = (target_sum >= MAX_W1) ? MAX_W : target_sum[W-1:0];
        end else if (down && !up) begin
            target_d = (target_q >= STEP_W) ? target_q - STEP_W : '0;
        end
    end

`ifdef DUTY_RAMP_SOFT_STOP_EN
    // Disabling just retargets the ramp to zero; OFF is never entered.
    assign goal   = en ? target_q : '0;
    assign go_off = 1'b0;
`else
    assign goal   = target_q;
    assign go_off = !en;
`endif

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        case (state_q)
            ST_IDLE: begin
                if (go_off)              state_d = ST_OFF;
                else if (goal > duty_q)  state_d = ST_RAMP_UP;
                else if (goal < duty_q)  state_d = ST_RAMP_DOWN;
            end
            ST_RAMP_UP: begin
                if (go_off)               state_d = ST_OFF;
                else if (goal < duty_q)   state_d = ST_RAMP_DOWN;
                else if (goal == duty_q)  state_d = ST_IDLE;
                else if (step) begin
                    duty_d = duty_q + 1'b1;
                    if (duty_d == goal)   state_d = ST_IDLE;
                end
            end
            ST_RAMP_DOWN: begin
                if (go_off)               state_d = ST_OFF;
                else if (goal > duty_q)   state_d = ST_RAMP_UP;
                else if (goal == duty_q)  state_d = ST_IDLE;
                else if (step) begin
                    duty_d = duty_q - 1'b1;
                    if (duty_d == goal)   state_d = ST_IDLE;
                end
            end
            ST_OFF: begin
                // The drop to zero waits for a period boundary so the running period completes.
                if (tick) duty_d = '0;
                if (en)   state_d = (target_q != '0) ? ST_RAMP_UP : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cnt_clr = (state_d == ST_RAMP_UP || state_d == ST_RAMP_DOWN) && (state_d != state_q);

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            target_q <= INIT_W;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
        end
    end

    assign duty   = duty_q;
    assign target = target_q;
    assign busy   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
    assign at_max = (target_q == MAX_W);
    assign at_min = (target_q == '0);

endmodule

// File: tb/tb_duty_ramp_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model.
module tb_duty_ramp_controller;

    localparam int W    = 6;
    localparam int MAXD = 50;
    localparam int STEP = 5;
    localparam int RT   = 4;
    localparam int INIT = 0;
`ifdef DUTY_RAMP_SOFT_STOP_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif

    logic         CLK, Reset, tick, up, down, en;
    logic [W-1:0] duty, target;
    logic         busy, at_max, at_min;

    int checks   = 0;
    int failures = 0;

    duty_ramp_controller #(
        .W(W), .MAX_DUTY(MAXD), .STEP(STEP), .RAMP_TICKS(RT), .INIT_TARGET(INIT)
    ) dut (
        .CLK(CLK), .Reset(Reset), .tick(tick), .up(up), .down(down), .en(en),
        .duty(duty), .target(target), .busy(busy), .at_max(at_max), .at_min(at_min)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 settled, 1 rising, 2 falling, 3 disabled.
    int m_tgt, m_duty, m_phase, m_mode;
    bit m_valid = 1'b0;
    bit last_tick, last_rst;
    int prev_duty;

    always @(posedge CLK) begin
        int nt, goal, diff, nm, dirn;
        bit stp;
        last_tick = tick;
        last_rst  = !Reset;
        if (!Reset) begin
            m_tgt = INIT; m_duty = 0; m_phase = 0; m_mode = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            nt = m_tgt;
            if (up && !down)      nt = (m_tgt + STEP > MAXD) ? MAXD : m_tgt + STEP;
            else if (down && !up) nt = (m_tgt < STEP) ? 0 : m_tgt - STEP;
            stp  = tick && (m_phase == RT - 1);
            goal = (SOFT && !en) ? 0 : m_tgt;
            diff = goal - m_duty;
            nm   = m_mode;
            if (m_mode == 3) begin
                if (tick) m_duty = 0;
                if (en)   nm = (m_tgt > 0) ? 1 : 0;
            end else if (!en && !SOFT) begin
                nm = 3;
            end else if (m_mode == 0) begin
                nm = (diff > 0) ? 1 : (diff < 0) ? 2 : 0;
            end else begin
                dirn = (m_mode == 1) ? 1 : -1;
                if (diff * dirn < 0) nm = 3 - m_mode;
                else if (diff == 0)  nm = 0;
                else if (stp) begin
                    m_duty += dirn;
                    if (m_duty == goal) nm = 0;
                end
            end
            if (tick) m_phase = (m_phase + 1) % RT;
            if ((nm == 1 || nm == 2) && nm != m_mode) m_phase = 0;
            m_mode = nm;
            m_tgt  = nt;
        end
    end

    always @(negedge CLK) begin
        if (m_valid) begin
            check("duty",   duty,   m_duty);
            check("target", target, m_tgt);
            check("busy",   busy,   (m_mode == 1 || m_mode == 2) ? 1 : 0);
            check("at_max", at_max, (m_tgt == MAXD) ? 1 : 0);
            check("at_min", at_min, (m_tgt == 0) ? 1 : 0);
            if (duty != prev_duty[W-1:0] && !last_rst) check("duty_on_tick", last_tick, 1);
            prev_duty = duty;
        end
    end

    task automatic drive(input bit t, input bit u, input bit d);
        @(negedge CLK);
        tick = t; up = u; down = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            drive(1, 0, 0);
            idle(9);
        end
    endtask

    task automatic ups(input int n);
        repeat (n) begin drive(0, 1, 0); idle(1); end
    endtask

    task automatic downs(input int n);
        repeat (n) begin drive(0, 0, 1); idle(1); end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        idle(2);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0; tick = 1'b0; up = 1'b0; down = 1'b0; en = 1'b0;
        prev_duty = 0;
        idle(2);
        Reset = 1'b1;
        check("rst_duty", duty, 0);
        check("rst_target", target, 0);
        check("rst_busy", busy, 0);
        check("rst_at_min", at_min, 1);

        // Ramp 0 -> 15, one LSB per 4 ticks.
        en = 1'b1;
        ups(3);
        idle(2);
        check("ramp_target", target, 15);
        check("ramp_busy_start", busy, 1);
        ticks(4);
        check("ramp_duty_t4", duty, 1);
        ticks(55);
        check("ramp_duty_t59", duty, 14);
        check("ramp_busy_t59", busy, 1);
        ticks(1);
        check("ramp_duty_t60", duty, 15);
        check("ramp_busy_t60", busy, 0);
        check("model_duty_t60", m_duty, 15);

        // Saturation at both ends and simultaneous pulses.
        ups(7);
        check("sat_target_50", target, 50);
        ups(1);
        check("sat_hold_max", target, 50);
        check("sat_at_max", at_max, 1);
        downs(10);
        check("sat_target_0", target, 0);
        downs(1);
        check("sat_hold_min", target, 0);
        check("sat_at_min", at_min, 1);
        ups(2);
        drive(0, 1, 1); idle(1);
        check("up_down_both", target, 10);

        // Reverse mid-ramp: duty 7 target 15, two downs -> target 5.
        do_reset();
        ups(3);
        ticks(28);
        check("mid_duty_7", duty, 7);
        downs(2);
        idle(2);
        check("mid_target_5", target, 5);
        check("mid_busy", busy, 1);
        check("mid_duty_held", duty, 7);
        ticks(4);
        check("mid_duty_6", duty, 6);
        ticks(4);
        check("mid_duty_5", duty, 5);
        check("mid_idle", busy, 0);

        // Disable with duty 20.
        do_reset();
        ups(4);
        ticks(80);
        check("off_duty_20", duty, 20);
        en = 1'b0;
        idle(3);
`ifdef DUTY_RAMP_SOFT_STOP_EN
        check("soft_busy", busy, 1);
        ticks(79);
        check("soft_duty_1", duty, 1);
        ticks(1);
        check("soft_duty_0", duty, 0);
        check("soft_idle", busy, 0);
`else
        check("off_not_immediate", duty, 20);
        ticks(1);
        check("off_duty_0", duty, 0);
        check("off_busy", busy, 0);
`endif
        en = 1'b1;

        // Reset mid-ramp at duty 9.
        do_reset();
        ups(3);
        ticks(36);
        check("rstmid_duty_9", duty, 9);
        Reset = 1'b0;
        idle(1);
        check("rstmid_duty", duty, 0);
        check("rstmid_target", target, INIT);
        check("rstmid_busy", busy, 0);
        Reset = 1'b1;

        // Randomised traffic against the model.
        for (int i = 0; i < 5000; i++) begin
            drive($urandom_range(5) == 0, $urandom_range(15) == 0, $urandom_range(15) == 0);
            if ($urandom_range(150) == 0) en = ~en;
            Reset = ($urandom_range(700) != 0);
        end
        Reset = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
